// File: rtl/clint_timer_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// the response FSM state type and a byte-merge helper for strobed stores.
package clint_timer_pkg;

    // Register offsets from the CLINT base address
    localparam logic [63:0] CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
    localparam logic [63:0] CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

    // MMIO response FSM
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } clint_state_t;

    // Merge a lane-aligned store into an existing doubleword under byte enables
    function automatic logic [63:0] byte_merge(
        input logic [63:0] old_data,
        input logic [63:0] new_data,
        input logic [7:0]  strobe
    );
        logic [63:0] merged;
        merged = old_data;
        for (int unsigned i = 0; i < 8; i++) begin
            if (strobe[i]) begin
                merged[i*8 +: 8] = new_data[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/clint_timer_sync2.sv
// Generic two-flop synchroniser with synchronous active-high reset.
module clint_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops to resolve metastability on an asynchronous input
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: memory-mapped mtime/mtimecmp/msip with a
// two-state MMIO response FSM, plus timer, software and synchronised
// external interrupt outputs for the CSR file.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic        req_write,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_strobe,
    output logic        resp_ok,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    input  logic        exint_async,
    output logic        trint,
    output logic        swint,
    output logic        exint,
    output logic [63:0] mtime_out
);

    // Absolute register addresses; decode uses only the doubleword part
    localparam logic [63:0] MSIP_ADDR     = BASE_ADDR + CLINT_MSIP_OFF;
    localparam logic [63:0] MTIMECMP_ADDR = BASE_ADDR + CLINT_MTIMECMP_OFF;
    localparam logic [63:0] MTIME_ADDR    = BASE_ADDR + CLINT_MTIME_OFF;
    localparam logic [31:0] TICK_LAST     = 32'(TICK_DIV - 1);

    clint_state_t state;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic [31:0] prescaler;

    logic [63:0] mtime_nxt;
    logic [63:0] mtimecmp_nxt;
    logic        msip_nxt;
    logic [31:0] prescaler_nxt;

    logic        accept;
    logic        hit_msip;
    logic        hit_mtimecmp;
    logic        hit_mtime;
    logic        hit_any;
    logic        do_store;
    logic        tick;
    logic [63:0] read_data;

    // Byte offset within a doubleword does not take part in decode
    logic        addr_lo_unused;
    assign addr_lo_unused = ^req_addr[2:0];

    // Address decode against each register's doubleword address
    always_comb begin
        hit_msip     = (req_addr[63:3] == MSIP_ADDR[63:3]);
        hit_mtimecmp = (req_addr[63:3] == MTIMECMP_ADDR[63:3]);
        hit_mtime    = (req_addr[63:3] == MTIME_ADDR[63:3]);
        hit_any      = hit_msip | hit_mtimecmp | hit_mtime;
    end

    // Read mux: value of the addressed register in the accept cycle
    always_comb begin
        read_data = '0;
        if (hit_msip) begin
            read_data = {63'd0, msip};
        end else if (hit_mtimecmp) begin
            read_data = mtimecmp;
        end else if (hit_mtime) begin
            read_data = mtime;
        end
    end

    // Next-state values: prescaled tick, then strobed store overriding the tick
    always_comb begin
        accept   = (state == IDLE) && req_valid;
        do_store = accept && req_write && (req_strobe != '0);
        tick     = (prescaler == TICK_LAST);

        prescaler_nxt = tick ? '0 : prescaler + 32'd1;

        // A store to mtime replaces the incremented value, so a coincident
        // tick is lost; the prescaler keeps running regardless.
        mtime_nxt = tick ? mtime + 64'd1 : mtime;
        if (do_store && hit_mtime) begin
            mtime_nxt = byte_merge(mtime, req_wdata, req_strobe);
        end

        mtimecmp_nxt = mtimecmp;
        if (do_store && hit_mtimecmp) begin
            mtimecmp_nxt = byte_merge(mtimecmp, req_wdata, req_strobe);
        end

        msip_nxt = msip;
        if (do_store && hit_msip && req_strobe[0]) begin
            msip_nxt = req_wdata[0];
        end
    end

    // Timer/software registers and the interrupt outputs derived from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime     <= '0;
            mtimecmp  <= MTIMECMP_RST;
            msip      <= 1'b0;
            prescaler <= '0;
            trint     <= 1'b0;
            swint     <= 1'b0;
        end else begin
            mtime     <= mtime_nxt;
            mtimecmp  <= mtimecmp_nxt;
            msip      <= msip_nxt;
            prescaler <= prescaler_nxt;
            trint     <= (mtime_nxt >= mtimecmp_nxt);
            swint     <= msip_nxt;
        end
    end

    // MMIO response FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_ok    <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= RESP;
                        resp_ok    <= 1'b1;
                        resp_err   <= ~hit_any;
                        resp_rdata <= (hit_any && !req_write) ? read_data : '0;
                    end else begin
                        resp_ok    <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_ok    <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    state      <= IDLE;
                    resp_ok    <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

    clint_sync2 u_exint_sync (
        .clk   (clk),
        .reset (reset),
        .d     (exint_async),
        .q     (exint)
    );

    assign mtime_out = mtime;

endmodule
